// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the decode hazard/stall controller.
// Holds the controller state encoding and the RISC-V opcode and register-index constants.
package hazard_stall_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_scoreboard.sv
// 32-entry countdown scoreboard of in-flight register writes; x0 is never busy.
// Set on issue, decrement each cycle; combinational busy query for rs1/rs2.
module hazard_scoreboard
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int WB_LAT     = 3,
    parameter int LOAD_EXTRA = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             set_load,
    input  logic [REG_W-1:0] rs1_sel,
    input  logic [REG_W-1:0] rs2_sel,
    output logic             rs1_busy,
    output logic             rs2_busy
);

    localparam int SB_W = $clog2(WB_LAT + LOAD_EXTRA + 1);
    localparam logic [SB_W-1:0] VAL_ALU  = SB_W'(WB_LAT);
    localparam logic [SB_W-1:0] VAL_LOAD = SB_W'(WB_LAT + LOAD_EXTRA);

    logic [SB_W-1:0] sb_q [32];
    logic [SB_W-1:0] sb_d [32];

    // A fresh issue to rd overrides that entry's decrement in the same cycle.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            sb_d[i] = sb_q[i];
            if (sb_q[i] != '0) begin
                sb_d[i] = sb_q[i] - SB_W'(1);
            end
            if (set_en && (set_idx == REG_W'(i))) begin
                sb_d[i] = set_load ? VAL_LOAD : VAL_ALU;
            end
        end
        sb_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign rs1_busy = (sb_q[rs1_sel] != '0);
    assign rs2_busy = (sb_q[rs2_sel] != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RAW hazard stall, fetch hold and branch flush sequencing for a non-forwarding pipeline.
// Outputs are combinational from registered state and decode inputs; pc_hold never sees branch_taken.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int WB_LAT       = 3,
    parameter int LOAD_EXTRA   = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1_sel,
    input  logic             dec_rs1_used,
    input  logic [REG_W-1:0] dec_rs2_sel,
    input  logic             dec_rs2_used,
    input  logic [REG_W-1:0] dec_rd_sel,
    input  logic             dec_wr_en,
    input  logic             dec_mem_en,
    input  logic             dec_mem_wr,
    input  logic             branch_taken,
    output logic             stall,
    output logic             pc_hold,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    ctrl_state_t      state_q, state_d;
    logic [FC_W-1:0]  fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_busy, rs2_busy;
    logic hazard, issue, sb_set;

    hazard_scoreboard #(
        .WB_LAT     (WB_LAT),
        .LOAD_EXTRA (LOAD_EXTRA)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_idx  (dec_rd_sel),
        .set_load (dec_mem_en & ~dec_mem_wr),
        .rs1_sel  (dec_rs1_sel),
        .rs2_sel  (dec_rs2_sel),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    assign hazard = dec_valid & ((dec_rs1_used & rs1_busy) | (dec_rs2_used & rs2_busy));
    assign issue  = dec_valid & ~hazard & (state_q == ST_RUN) & ~branch_taken;
    assign sb_set = issue & dec_wr_en & (dec_rd_sel != '0);

    // PC hold is RUN-only so the redirect target can load while flushing.
    assign flush   = (state_q == ST_FLUSH);
    assign pc_hold = (state_q == ST_RUN) & hazard;
    assign stall   = branch_taken | flush | pc_hold;

    always_comb begin
        state_d     = state_q;
        fl_cnt_d    = fl_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (branch_taken) begin
            state_d  = ST_FLUSH;
            fl_cnt_d = FC_W'(FLUSH_CYCLES);
        end else if (state_q == ST_FLUSH) begin
            if (fl_cnt_q == FC_W'(1)) begin
                state_d  = ST_RUN;
                fl_cnt_d = '0;
            end else begin
                fl_cnt_d = fl_cnt_q - FC_W'(1);
            end
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fl_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fl_cnt_q    <= fl_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
